apb3_master_bridge: RTL and testbench
=====================================

Name: apb3_master_bridge

Overview:
- Converts a simple valid/ready request stream into APB3 master transfers, one at a time, and returns each result on a valid/ready response channel.
- Sits directly upstream of uart_top's APB3 slave port. Firmware-side logic, or a bench sequencer, drives UART registers through it instead of toggling PSEL/PENABLE by hand.
- Adds a PREADY timeout so a hung slave cannot stall the requester.

Parameters:
- APB_ADDR_WIDTH, 32, width of request address and PADDR.
- APB_DATA_WIDTH, 32, width of write/read data, PWDATA and PRDATA.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles waiting for PREADY; 0 disables the timeout.

Ports:
- i_apb_pclk  in  1  single clock for the block and the APB bus.
- i_apb_preset  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  bridge accepts a request.
- i_req_addr  in  APB_ADDR_WIDTH  target address.
- i_req_wdata  in  APB_DATA_WIDTH  write data; ignored for reads.
- i_req_write  in  1  1 = write, 0 = read.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  requester accepts the response.
- o_rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts.
- o_rsp_err  out  1  PSLVERR seen, or timeout.
- o_rsp_timeout  out  1  transfer aborted by timeout.
- o_busy  out  1  state is not IDLE.
- o_apb_paddr  out  APB_ADDR_WIDTH  APB PADDR.
- o_apb_pwdata  out  APB_DATA_WIDTH  APB PWDATA.
- o_apb_pwrite  out  1  APB PWRITE.
- o_apb_psel  out  1  APB PSEL.
- o_apb_penable  out  1  APB PENABLE.
- i_apb_prdata  in  APB_DATA_WIDTH  APB PRDATA.
- i_apb_pready  in  1  APB PREADY.
- i_apb_pslverr  in  1  APB PSLVERR.

Behaviour:
- Clock and reset: single clock i_apb_pclk; reset i_apb_preset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0 except o_req_ready = 1; timeout counter 0.
- Reset mid-transfer: at the first edge where i_apb_preset is sampled high, PSEL, PENABLE and o_rsp_valid drop, the transfer is discarded, and no response is issued.
- All outputs are registered. Exception: o_req_ready is decoded directly from state IDLE.

FSM states:
- IDLE
  - o_req_ready = 1.
  - On i_req_valid: latch addr, wdata and write into PADDR, PWDATA and PWRITE; go to SETUP next cycle.
  - PWDATA is forced to 0 for reads.
- SETUP
  - PSEL = 1, PENABLE = 0, held for exactly 1 cycle; then go to ACCESS.
  - Timeout counter is cleared.
- ACCESS
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the final ACCESS cycle.
  - Each cycle with PREADY = 0 increments the counter.
  - PREADY = 1:
    - capture PRDATA into o_rsp_rdata (reads only; writes return 0);
    - o_rsp_err = PSLVERR; o_rsp_timeout = 0;
    - go to RESP.
  - Counter == TIMEOUT_CYCLES - 1 with PREADY still 0 (TIMEOUT_CYCLES > 0 only):
    - abort: o_rsp_err = 1, o_rsp_timeout = 1, o_rsp_rdata = 0;
    - go to RESP.
  - If PREADY = 1 arrives in the same cycle the timeout would fire, PREADY wins.
- RESP
  - PSEL = 0, PENABLE = 0, o_rsp_valid = 1; response fields held stable.
  - On i_rsp_ready: go to IDLE next cycle and clear o_rsp_valid.

Handshake and throughput:
- Only one transfer is outstanding; o_req_ready = 0 outside IDLE.
- Requests are accepted on i_req_valid && o_req_ready; responses complete on o_rsp_valid && i_rsp_ready.
- Latency with zero-wait-state PREADY and i_rsp_ready tied 1:
  - accept (IDLE) → SETUP +1 → ACCESS +2 → o_rsp_valid at +3;
  - next accept at +4, so the minimum period is 4 cycles per transfer.
- Each PREADY wait state adds 1 cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- The counter saturates; it cannot wrap, since the timeout fires before wrap.

Test Plan:
- Write, zero wait: req addr 0x08, wdata 0xA5, write=1; PREADY=1 → PSEL high 2 cycles, PENABLE in the 2nd, PADDR=0x08, PWDATA=0xA5; o_rsp_valid 3 cycles after accept, err=0, rdata=0.
- Read with 3 wait states: PREADY low 3 ACCESS cycles, then high with PRDATA=0x1234_5678 → ACCESS lasts 4 cycles, o_rsp_rdata=0x12345678, addr/data stable throughout.
- Slave error: read with PSLVERR=1 at PREADY → o_rsp_err=1, o_rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, PREADY held 0 → abort after 8 ACCESS cycles, PSEL drops, err=1, timeout=1, rdata=0.
- Response backpressure plus back-to-back: i_rsp_ready low 5 cycles with a second request pending → o_req_ready stays 0, response held stable; second transfer starts only after the response handshake.
- Reset mid-ACCESS: assert i_apb_preset during wait states → next edge PSEL=0, PENABLE=0, o_rsp_valid=0, o_req_ready=1; no stale response after reset release.

Source files
------------

// File: rtl/apb3_master_bridge.sv
// APB3 master bridge: valid/ready request stream in, one APB3 transfer at a time,
// valid/ready response out, with an optional PREADY timeout.
module apb3_master_bridge #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      i_apb_pclk,
   input  logic                      i_apb_preset,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
   input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
   input  logic                      i_req_write,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                      o_rsp_err,
   output logic                      o_rsp_timeout,
   output logic                      o_busy,
   output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
   output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
   output logic                      o_apb_pwrite,
   output logic                      o_apb_psel,
   output logic                      o_apb_penable,
   input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
   input  logic                      i_apb_pready,
   input  logic                      i_apb_pslverr
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TLIM_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] TLIM = CW'(TLIM_I);

   logic [1:0]    state;
   logic [CW-1:0] cnt;

   assign o_req_ready = (state == IDLE);

   always_ff @(posedge i_apb_pclk) begin
      if (i_apb_preset) begin
         state         <= IDLE;
         cnt           <= '0;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_err     <= 1'b0;
         o_rsp_timeout <= 1'b0;
         o_busy        <= 1'b0;
         o_apb_paddr   <= '0;
         o_apb_pwdata  <= '0;
         o_apb_pwrite  <= 1'b0;
         o_apb_psel    <= 1'b0;
         o_apb_penable <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_req_valid) begin
                  o_apb_paddr  <= i_req_addr;
                  o_apb_pwdata <= i_req_write ? i_req_wdata : '0;
                  o_apb_pwrite <= i_req_write;
                  o_apb_psel   <= 1'b1;
                  o_busy       <= 1'b1;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               o_apb_penable <= 1'b1;
               cnt           <= '0;
               state         <= ACCESS;
            end
            ACCESS: begin
               // PREADY takes priority over a timeout firing in the same cycle
               if (i_apb_pready) begin
                  o_apb_psel    <= 1'b0;
                  o_apb_penable <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_rdata   <= o_apb_pwrite ? '0 : i_apb_prdata;
                  o_rsp_err     <= i_apb_pslverr;
                  o_rsp_timeout <= 1'b0;
                  state         <= RESP;
               end else if (TO_EN && cnt == TLIM) begin
                  o_apb_psel    <= 1'b0;
                  o_apb_penable <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_rdata   <= '0;
                  o_rsp_err     <= 1'b1;
                  o_rsp_timeout <= 1'b1;
                  state         <= RESP;
               end else if (cnt != {CW{1'b1}}) begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_busy      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge: zero-wait write, wait states,
// slave error, timeout, response backpressure and mid-transfer reset.
module tb_apb3_master_bridge;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_write;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int vectors = 0;
   int miscompares = 0;

   apb3_master_bridge #(
      .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .i_apb_pclk   (clk),
      .i_apb_preset (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_write  (req_write),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_err    (rsp_err),
      .o_rsp_timeout(rsp_timeout),
      .o_busy       (busy),
      .o_apb_paddr  (paddr),
      .o_apb_pwdata (pwdata),
      .o_apb_pwrite (pwrite),
      .o_apb_psel   (psel),
      .o_apb_penable(penable),
      .i_apb_prdata (prdata),
      .i_apb_pready (pready),
      .i_apb_pslverr(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_write = 1'b0;
      rsp_ready = 1'b1;
      prdata = '0;
      pready = 1'b1;
      pslverr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);

      // write, zero wait states
      req_valid = 1'b1;
      req_addr = 32'h08;
      req_wdata = 32'hA5;
      req_write = 1'b1;
      pready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_setup_psel", 32'(psel), 32'd1);
      chk("wr_setup_penable", 32'(penable), 32'd0);
      chk("wr_setup_paddr", paddr, 32'h08);
      chk("wr_setup_pwdata", pwdata, 32'hA5);
      chk("wr_setup_pwrite", 32'(pwrite), 32'd1);
      chk("wr_setup_req_ready", 32'(req_ready), 32'd0);
      chk("wr_setup_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("wr_access_psel", 32'(psel), 32'd1);
      chk("wr_access_penable", 32'(penable), 32'd1);
      chk("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("wr_resp_valid", 32'(rsp_valid), 32'd1);
      chk("wr_resp_psel", 32'(psel), 32'd0);
      chk("wr_resp_penable", 32'(penable), 32'd0);
      chk("wr_resp_err", 32'(rsp_err), 32'd0);
      chk("wr_resp_rdata", rsp_rdata, 32'd0);
      chk("wr_resp_timeout", 32'(rsp_timeout), 32'd0);
      @(negedge clk);
      chk("wr_done_valid", 32'(rsp_valid), 32'd0);
      chk("wr_done_req_ready", 32'(req_ready), 32'd1);
      chk("wr_done_busy", 32'(busy), 32'd0);

      // read with 3 wait states
      req_valid = 1'b1;
      req_addr = 32'h10;
      req_wdata = 32'hDEAD;
      req_write = 1'b0;
      pready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_setup_pwdata", pwdata, 32'd0);
      chk("rd_setup_pwrite", 32'(pwrite), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rd_wait_psel", 32'(psel), 32'd1);
         chk("rd_wait_penable", 32'(penable), 32'd1);
         chk("rd_wait_paddr", paddr, 32'h10);
         chk("rd_wait_pwdata", pwdata, 32'd0);
         chk("rd_wait_rsp_valid", 32'(rsp_valid), 32'd0);
         if (i == 3) begin
            pready = 1'b1;
            prdata = 32'h1234_5678;
         end
      end
      @(negedge clk);
      chk("rd_resp_valid", 32'(rsp_valid), 32'd1);
      chk("rd_resp_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd_resp_err", 32'(rsp_err), 32'd0);
      prdata = '0;
      @(negedge clk);

      // slave error on a read
      req_valid = 1'b1;
      req_addr = 32'h14;
      req_write = 1'b0;
      pready = 1'b1;
      pslverr = 1'b1;
      prdata = 32'h0000_CAFE;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("err_resp_valid", 32'(rsp_valid), 32'd1);
      chk("err_resp_err", 32'(rsp_err), 32'd1);
      chk("err_resp_timeout", 32'(rsp_timeout), 32'd0);
      chk("err_resp_rdata", rsp_rdata, 32'h0000_CAFE);
      pslverr = 1'b0;
      prdata = '0;
      @(negedge clk);

      // timeout: PREADY never rises
      req_valid = 1'b1;
      req_addr = 32'h18;
      req_write = 1'b0;
      pready = 1'b0;
      prdata = 32'hFFFF_FFFF;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("to_wait_psel", 32'(psel), 32'd1);
         chk("to_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
      chk("to_resp_psel", 32'(psel), 32'd0);
      chk("to_resp_valid", 32'(rsp_valid), 32'd1);
      chk("to_resp_err", 32'(rsp_err), 32'd1);
      chk("to_resp_timeout", 32'(rsp_timeout), 32'd1);
      chk("to_resp_rdata", rsp_rdata, 32'd0);
      prdata = '0;
      pready = 1'b1;
      @(negedge clk);

      // response backpressure with a second request pending
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr = 32'h0C;
      req_wdata = 32'h55;
      req_write = 1'b1;
      prdata = 32'h0BAD_F00D;
      @(negedge clk);
      req_addr = 32'h20;
      req_wdata = 32'h77;
      req_write = 1'b0;
      chk("bp_setup_paddr", paddr, 32'h0C);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
         chk("bp_hold_psel", 32'(psel), 32'd0);
         chk("bp_hold_rdata", rsp_rdata, 32'd0);
         chk("bp_hold_err", 32'(rsp_err), 32'd0);
      end
      @(negedge clk);
      chk("bp_still_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
      chk("bp_idle_req_ready", 32'(req_ready), 32'd1);
      chk("bp_idle_psel", 32'(psel), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp2_setup_psel", 32'(psel), 32'd1);
      chk("bp2_setup_paddr", paddr, 32'h20);
      chk("bp2_setup_pwrite", 32'(pwrite), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("bp2_resp_valid", 32'(rsp_valid), 32'd1);
      chk("bp2_resp_rdata", rsp_rdata, 32'h0BAD_F00D);
      prdata = '0;
      @(negedge clk);

      // reset during ACCESS wait states
      req_valid = 1'b1;
      req_addr = 32'h24;
      req_write = 1'b0;
      pready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rm_access_penable", 32'(penable), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rm_psel", 32'(psel), 32'd0);
      chk("rm_penable", 32'(penable), 32'd0);
      chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rm_req_ready", 32'(req_ready), 32'd1);
      chk("rm_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      pready = 1'b1;
      prdata = 32'h5555_AAAA;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rm_after_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rm_after_psel", 32'(psel), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
